// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, line levels and the
// CeilLog2 width helper used to size counters in every UART block.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    // Clamped to 1 so a counter for a single state still gets one bit.
    function automatic int unsigned CeilLog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Modulo-CLKS_PER_BIT baud counter with enable and synchronous clear; emits a
// one-cycle tick at terminal count. Synchronous active-low reset.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                en,
    input  logic                                clr,
    output logic [CeilLog2(CLKS_PER_BIT)-1:0]   count,
    output logic                                tick
);

    localparam int unsigned      CNT_W    = CeilLog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign tick  = en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: valid/ready byte intake, serialised as start,
// data LSB-first, optional even parity (UART_TX_PARITY_EN) and stop bit(s).
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned      CNT_W     = CeilLog2(CLKS_PER_BIT);
    localparam int unsigned      BIT_W     = CeilLog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] DONE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_ctrl: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
    end

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 serial_q, serial_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic             handshake;
    logic             baud_tick;
    logic [CNT_W-1:0] baud_cnt;

    assign handshake = tx_valid && ready_q;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state_q != IDLE),
        .clr   (handshake),
        .count (baud_cnt),
        .tick  (baud_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        serial_d  = serial_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    serial_d = START_LVL;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    serial_d  = shift_q[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        serial_d  = parity_q;
`else
                        state_d   = STOP;
                        bit_cnt_d = '0;
                        serial_d  = LINE_IDLE;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        serial_d  = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    serial_d  = LINE_IDLE;
                end
            end
`endif
            STOP: begin
                // Done is registered, so it is raised one count early to land on the last stop cycle.
                done_d = (bit_cnt_q == LAST_STOP) && (baud_cnt == DONE_CNT);
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = LINE_IDLE;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            serial_q  <= LINE_IDLE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            serial_q  <= serial_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx_ready  = ready_q;
    assign tx_serial = serial_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: words are queued when driven, and each
// frame seen on the line is checked bit-by-bit against the popped word.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       reset2 = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_ready, tx_serial, tx_busy, tx_done;
    logic       tx_ready2, tx_serial2, tx_busy2, tx_done2;
    logic       sel = 1'b0;
    logic       mon_ready, mon_serial, mon_busy, mon_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(8),
        .STOP_BITS(1)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(8),
        .STOP_BITS(2)
    ) u_dut_stop2 (
        .clk       (clk),
        .reset     (reset2),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready2),
        .tx_serial (tx_serial2),
        .tx_busy   (tx_busy2),
        .tx_done   (tx_done2)
    );

    assign mon_ready  = sel ? tx_ready2  : tx_ready;
    assign mon_serial = sel ? tx_serial2 : tx_serial;
    assign mon_busy   = sel ? tx_busy2   : tx_busy;
    assign mon_done   = sel ? tx_done2   : tx_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Waits for a start bit, pops the expected word and checks every cycle of the frame
    // plus the idle cycle after it. pulse_at > 0 pulses tx_valid during that frame cycle.
    task automatic watch_frame(input int stop_bits, input int max_wait, input bit hold,
                               input logic [7:0] next_data, input int pulse_at);
        logic [7:0] w;
        logic       bits[$];
        bit         seen;
        int         n;
        seen = 0;
        for (int i = 0; i < max_wait && !seen; i++) begin
            @(negedge clk);
            if (mon_serial === 1'b0) seen = 1;
        end
        if (!seen) begin
            check_eq("start_seen", 0, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            check_eq("unexpected_frame", 1, 0);
            return;
        end
        w = exp_q.pop_front();
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(w[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^w);
`endif
        for (int i = 0; i < stop_bits; i++) bits.push_back(1'b1);
        n = bits.size() * CPB;
        tx_data = next_data;
        if (!hold) tx_valid = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (c > 1) @(negedge clk);
            if (pulse_at > 0 && c == pulse_at) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
            if (pulse_at > 0 && c == pulse_at + 1) tx_valid = 1'b0;
            check_eq("serial", mon_serial, bits[(c - 1) / CPB]);
            check_eq("done", mon_done, (c == n));
            if ((c - 1) % CPB == 0) begin
                check_eq("busy_in_frame", mon_busy, 1);
                check_eq("ready_in_frame", mon_ready, 0);
            end
        end
        @(negedge clk);
        check_eq("post_serial", mon_serial, 1);
        check_eq("post_ready", mon_ready, 1);
        check_eq("post_busy", mon_busy, 0);
        check_eq("post_done", mon_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         seen;
        bit         bad;
        logic [7:0] d;

        // tx_valid held during reset must be ignored
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_serial", tx_serial, 1);
            check_eq("rst_ready", tx_ready, 1);
            check_eq("rst_busy", tx_busy, 0);
            check_eq("rst_done", tx_done, 0);
        end
        exp_q.push_back(8'hA5);
        reset = 1'b1;
        watch_frame(1, 1, 0, 8'h3C, 0);

        // parity-sensitive words plus random traffic
        for (int k = 0; k < 6; k++) begin
            d = (k == 0) ? 8'h07 : (k == 1) ? 8'h03 : 8'($urandom);
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = d;
            exp_q.push_back(d);
            watch_frame(1, 3, 0, 8'($urandom), 0);
        end

        // back-to-back with tx_valid held; data changed mid-frame
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        watch_frame(1, 3, 1, 8'hAA, 0);
        watch_frame(1, 1, 0, 8'($urandom), 0);

        // tx_valid pulsed while busy
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        exp_q.push_back(8'h5A);
        watch_frame(1, 3, 0, 8'h00, 10);
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_done !== 1'b0) seen = 1;
        end
        check_eq("no_extra_frame", seen, 0);
        check_eq("queue_empty", exp_q.size(), 0);

        // reset during data bit 3
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        seen = 0;
        for (int i = 0; i < 3 && !seen; i++) begin
            @(negedge clk);
            if (tx_serial === 1'b0) seen = 1;
        end
        check_eq("abort_start_seen", seen, 1);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        check_eq("abort_bit3", tx_serial, 0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_serial", tx_serial, 1);
        check_eq("abort_busy", tx_busy, 0);
        check_eq("abort_ready", tx_ready, 1);
        check_eq("abort_done", tx_done, 0);
        reset = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || tx_serial !== 1'b1 || tx_busy !== 1'b0) bad = 1;
        end
        check_eq("abort_quiet", bad, 0);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h96;
        exp_q.push_back(8'h96);
        watch_frame(1, 3, 0, 8'h69, 0);

        // two stop bits on the second instance
        reset = 1'b0;
        sel   = 1'b1;
        @(negedge clk);
        reset2 = 1'b1;
        check_eq("stop2_idle_ready", tx_ready2, 1);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hE1;
        exp_q.push_back(8'hE1);
        watch_frame(2, 3, 0, 8'h1E, 0);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h3B;
        exp_q.push_back(8'h3B);
        watch_frame(2, 3, 0, 8'h00, 0);
        check_eq("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
